// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Multi-cycle ALU with valid/ready handshakes. Logic, add/sub,
//                compare and shift ops finish in one cycle; MUL/DIVU/REMU
//                iterate one bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_XOR  = 4'b0011;
    localparam logic [3:0] c_OP_SLL  = 4'b0100;
    localparam logic [3:0] c_OP_SRL  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_SLTU = 4'b1000;
    localparam logic [3:0] c_OP_SRA  = 4'b1001;
    localparam logic [3:0] c_OP_MUL  = 4'b1010;
    localparam logic [3:0] c_OP_DIVU = 4'b1100;
    localparam logic [3:0] c_OP_REMU = 4'b1101;

    localparam logic [1:0] c_MK_MUL  = 2'd0;
    localparam logic [1:0] c_MK_DIVU = 2'd1;
    localparam logic [1:0] c_MK_REMU = 2'd2;

    localparam logic [SHW:0] c_COUNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] c_COUNT_ONE  = (SHW+1)'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [SHW:0]     r_count;
    logic [1:0]       r_mkind;
    logic [WIDTH-1:0] r_acc;     // product accumulator / partial remainder
    logic [WIDTH-1:0] r_opa;     // shifted multiplicand / dividend-quotient
    logic [WIDTH-1:0] r_opb;     // shifted multiplier / divisor
    logic [WIDTH-1:0] r_result;
    logic             r_illegal;

    logic [WIDTH-1:0] w_single_result;
    logic             w_single_illegal;
    logic             w_is_long;
    logic [1:0]       w_mkind;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] w_mul_acc_next;
    logic [WIDTH:0]   w_div_trial;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_long_result;

    assign in_ready   = (r_state == c_ST_IDLE);
    assign out_valid  = (r_state == c_ST_DONE);
    assign alu_result = r_result;
    assign zero_flag  = (r_result == '0);
    assign illegal_op = r_illegal;

    assign w_accept = (r_state == c_ST_IDLE) && in_valid;
    assign w_last   = (r_state == c_ST_BUSY) && (r_count == c_COUNT_ONE);

    always_comb begin
        w_single_result  = '0;
        w_single_illegal = 1'b0;
        w_is_long        = 1'b0;
        w_mkind          = c_MK_MUL;
        case (alu_control)
            c_OP_AND:  w_single_result = a & b;
            c_OP_OR:   w_single_result = a | b;
            c_OP_ADD:  w_single_result = a + b;
            c_OP_XOR:  w_single_result = a ^ b;
            c_OP_SLL:  w_single_result = a << b[SHW-1:0];
            c_OP_SRL:  w_single_result = a >> b[SHW-1:0];
            c_OP_SUB:  w_single_result = a - b;
            c_OP_SLT:  w_single_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SLTU: w_single_result = {{(WIDTH-1){1'b0}}, (a < b)};
            c_OP_SRA:  w_single_result = $signed(a) >>> b[SHW-1:0];
            c_OP_MUL: begin
                w_is_long = 1'b1;
                w_mkind   = c_MK_MUL;
            end
            c_OP_DIVU: begin
                w_is_long = 1'b1;
                w_mkind   = c_MK_DIVU;
            end
            c_OP_REMU: begin
                w_is_long = 1'b1;
                w_mkind   = c_MK_REMU;
            end
            default:   w_single_illegal = 1'b1;
        endcase
    end

    // Restoring division: a zero divisor never yields a negative trial, so
    // the quotient saturates to all ones and the remainder collects a.
    assign w_mul_acc_next = r_opb[0] ? (r_acc + r_opa) : r_acc;
    assign w_div_trial    = {r_acc, r_opa[WIDTH-1]} - {1'b0, r_opb};
    assign w_div_ok       = ~w_div_trial[WIDTH];
    assign w_rem_next     = w_div_ok ? w_div_trial[WIDTH-1:0]
                                     : {r_acc[WIDTH-2:0], r_opa[WIDTH-1]};
    assign w_quo_next     = {r_opa[WIDTH-2:0], w_div_ok};

    always_comb begin
        w_long_result = w_mul_acc_next;
        case (r_mkind)
            c_MK_DIVU: w_long_result = w_quo_next;
            c_MK_REMU: w_long_result = w_rem_next;
            default:   w_long_result = w_mul_acc_next;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = w_is_long ? c_ST_BUSY : c_ST_DONE;
                end
            end
            c_ST_BUSY: begin
                if (r_count == c_COUNT_ONE) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_mkind   <= c_MK_MUL;
            r_acc     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_mkind <= w_mkind;
            r_acc   <= '0;
            r_opa   <= a;
            r_opb   <= b;
            if (w_is_long) begin
                r_count <= c_COUNT_INIT;
            end else begin
                r_count   <= '0;
                r_result  <= w_single_result;
                r_illegal <= w_single_illegal;
            end
        end else if (r_state == c_ST_BUSY) begin
            r_count <= r_count - c_COUNT_ONE;
            if (r_mkind == c_MK_MUL) begin
                r_acc <= w_mul_acc_next;
                r_opa <= r_opa << 1;
                r_opb <= r_opb >> 1;
            end else begin
                r_acc <= w_rem_next;
                r_opa <= w_quo_next;
            end
            if (w_last) begin
                r_result  <= w_long_result;
                r_illegal <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
